// File: rtl/edge_feeder.sv
// Edge feeder: buffers incoming array columns in a small FIFO and launches them into the
// left edge of the PE array with a diagonal skew. Lane y sees its word y cycles after lane 0.
// A frame ends with a column flagged last. After that column is popped, no further column
// is popped until that column's word has reached the final lane.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   reset_l    : asynchronous active-low reset
//   en         : advance enable; when low, the read side, skew pipe, FSM and counters hold
//   in_valid   : in_data / in_last hold a column
//   in_ready   : FIFO has room (registered; no combinational path from in_valid or en)
//   in_data    : one column; lane y is at bits [y*2*DW +: 2*DW], packed {field1, field0}
//   in_last    : the column is the final column of a frame
//   lane_data  : skewed words to the array row inputs, same lane packing as in_data
//   lane_valid : per-lane word valid
//   busy       : a frame is in flight (RUN or DRAIN)
//   done       : high in the cycle the last column's word is on the final lane
//   issued_cnt : number of columns popped since reset (wraps)
module edge_feeder #(
   parameter int unsigned YMAX  = 3,
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [YMAX*2*DW-1:0] in_data,
   input  logic                 in_last,
   output logic [YMAX*2*DW-1:0] lane_data,
   output logic [YMAX-1:0]      lane_valid,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          issued_cnt
);

   localparam int unsigned WW = 2 * DW;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (YMAX > 1) ? $clog2(YMAX) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   drain_q, drain_d;

   logic [YMAX*WW-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]   last_mem_q;
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        count_q, count_d;
   logic               in_ready_q;
   logic [15:0]        issued_q;
   logic [YMAX-1:0]    last_pipe_q;

   logic               push, pop;
   logic [YMAX*WW-1:0] head_data;
   logic               head_last;

   assign push      = in_valid & in_ready_q;
   assign pop       = en & (count_q != '0) & (state_q != StDrain);
   assign head_data = mem_q[rd_ptr_q];
   assign head_last = last_mem_q[rd_ptr_q];

   // ---------------------------------------------------------------- column FIFO
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   // Storage is not reset; only entries below the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q]      <= in_data;
         last_mem_q[wr_ptr_q] <= in_last;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
         issued_q   <= '0;
      end else begin
         count_q    <= count_d;
         in_ready_q <= (count_d != (AW + 1)'(DEPTH));
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            issued_q <= issued_q + 16'd1;
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign issued_cnt = issued_q;

   // ---------------------------------------------------------------- frame FSM
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (en) begin
         unique case (state_q)
            StIdle, StRun: begin
               if (pop) begin
                  if (head_last) begin
                     // With a single lane the last word is already on the final lane.
                     if (YMAX > 1) begin
                        state_d = StDrain;
                        drain_d = CW'(YMAX - 1);
                     end else begin
                        state_d = StIdle;
                     end
                  end else begin
                     state_d = StRun;
                  end
               end
            end
            StDrain: begin
               drain_d = drain_q - CW'(1);
               if (drain_q <= CW'(1)) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= StIdle;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign busy = (state_q != StIdle);

   // ---------------------------------------------------------------- skew pipeline
   // Lane y owns y+1 stages; stage 0 is loaded from the head column on pop, stage y drives
   // the lane output. Stage 0 data holds when nothing is popped, only its valid clears.
   for (genvar y = 0; y < YMAX; y++) begin : g_lane
      logic [WW-1:0] dq_q [y+1];
      logic [y:0]    vq_q;

      always_ff @(posedge clk or negedge reset_l) begin
         if (!reset_l) begin
            for (int k = 0; k <= y; k++) begin
               dq_q[k] <= '0;
            end
            vq_q <= '0;
         end else if (en) begin
            vq_q[0] <= pop;
            if (pop) begin
               dq_q[0] <= head_data[y*WW +: WW];
            end
            for (int k = 1; k <= y; k++) begin
               dq_q[k] <= dq_q[k-1];
               vq_q[k] <= vq_q[k-1];
            end
         end
      end

      assign lane_data[y*WW +: WW] = dq_q[y];
      assign lane_valid[y]         = vq_q[y];
   end

   // The last flag rides alongside the final lane so done lines up with its word.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         last_pipe_q <= '0;
      end else if (en) begin
         last_pipe_q[0] <= pop & head_last;
         for (int k = 1; k < YMAX; k++) begin
            last_pipe_q[k] <= last_pipe_q[k-1];
         end
      end
   end

   assign done = last_pipe_q[YMAX-1];

endmodule

// File: tb/tb_edge_feeder.sv
// Self-checking bench for edge_feeder: directed frame scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based behavioural model.
module tb_edge_feeder;

   localparam int unsigned YMAX  = 3;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned WW    = 2 * DW;
   localparam int unsigned LW    = YMAX * WW;
   localparam int          YM    = YMAX;

   logic          clk      = 1'b0;
   logic          reset_l  = 1'b0;
   logic          en       = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last  = 1'b0;
   logic [LW-1:0] in_data  = '0;
   logic          in_ready;
   logic [LW-1:0] lane_data;
   logic [YMAX-1:0] lane_valid;
   logic          busy;
   logic          done;
   logic [15:0]   issued_cnt;

   edge_feeder #(
      .YMAX (YMAX),
      .DW   (DW),
      .DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .lane_data (lane_data),
      .lane_valid(lane_valid),
      .busy      (busy),
      .done      (done),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   // ---------------------------------------------------------------- behavioural model
   // Columns waiting in the FIFO are a queue. Every pop is recorded against the index of the
   // enabled edge it happened on; lane y then shows the column popped y enabled edges ago.
   logic [LW-1:0] mq_data [$];
   bit            mq_last [$];
   logic [LW-1:0] pop_data [int];
   bit            pop_last [int];
   int            t_en          = 0;
   int            blocked_until = 0;
   int            drain_end     = 0;
   bit            open_frame    = 1'b0;
   bit            m_ready       = 1'b1;
   int unsigned   m_issued      = 0;
   logic [WW-1:0] m_lane0       = '0;

   always @(posedge clk or negedge reset_l) begin : model
      logic [LW-1:0] hd;
      bit            hl;
      if (!reset_l) begin
         mq_data.delete();
         mq_last.delete();
         pop_data.delete();
         pop_last.delete();
         t_en          = 0;
         blocked_until = 0;
         drain_end     = 0;
         open_frame    = 1'b0;
         m_ready       = 1'b1;
         m_issued      = 0;
         m_lane0       = '0;
      end else begin
         if (en) begin
            t_en++;
            if (mq_data.size() > 0 && t_en >= blocked_until) begin
               hd = mq_data.pop_front();
               hl = mq_last.pop_front();
               pop_data[t_en] = hd;
               pop_last[t_en] = hl;
               m_issued++;
               m_lane0 = hd[WW-1:0];
               if (hl) begin
                  // next frame may start once this word has left the final lane's input
                  blocked_until = t_en + YM;
                  drain_end     = t_en + YM - 1;
                  open_frame    = 1'b0;
               end else begin
                  open_frame = 1'b1;
               end
            end
            if (pop_data.exists(t_en - YM)) begin
               pop_data.delete(t_en - YM);
               pop_last.delete(t_en - YM);
            end
         end
         if (in_valid && m_ready) begin
            mq_data.push_back(in_data);
            mq_last.push_back(in_last);
         end
         m_ready = (mq_data.size() < DEPTH);
      end
   end

   always @(negedge clk) begin : compare
      logic [LW-1:0] w;
      bit            v;
      bit            exp_done;
      exp_done = 1'b0;
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(open_frame || (t_en < drain_end)));
      chk("issued_cnt", 64'(issued_cnt), 64'(16'(m_issued)));
      chk("lane0_data", 64'(lane_data[WW-1:0]), 64'(m_lane0));
      for (int y = 0; y < YM; y++) begin
         v = pop_data.exists(t_en - y);
         chk($sformatf("lane%0d_valid", y), 64'(lane_valid[y]), 64'(v));
         if (v) begin
            w = pop_data[t_en - y];
            chk($sformatf("lane%0d_data", y), 64'(lane_data[y*WW +: WW]), 64'(w[y*WW +: WW]));
            if (y == YM - 1) begin
               exp_done = pop_last[t_en - y];
            end
         end
      end
      chk("done", 64'(done), 64'(exp_done));
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [LW-1:0] c [6];

      for (int i = 0; i < 6; i++) begin
         c[i] = {$urandom, $urandom, $urandom};
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_lane_valid", 64'(lane_valid), 64'(0));
      chk("rst_lane_data", 64'(lane_data[63:0]), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_issued", 64'(issued_cnt), 64'(0));
      reset_l = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      // Three-column frame with en held high
      en = 1'b1;
      in_valid = 1'b1; in_data = c[0]; in_last = 1'b0;
      @(negedge clk);                                   // accept c0
      in_data = c[1];
      @(negedge clk);                                   // accept c1, pop c0
      chk("f1_valid_a", 64'(lane_valid), 64'(3'b001));
      chk("f1_lane0_c0", 64'(lane_data[WW-1:0]), 64'(c[0][WW-1:0]));
      chk("f1_busy", 64'(busy), 64'(1));
      in_data = c[2]; in_last = 1'b1;
      @(negedge clk);                                   // accept c2, pop c1
      in_valid = 1'b0; in_last = 1'b0;
      chk("f1_valid_b", 64'(lane_valid), 64'(3'b011));
      @(negedge clk);                                   // pop c2 (last)
      chk("f1_valid_c", 64'(lane_valid), 64'(3'b111));
      chk("f1_done_early", 64'(done), 64'(0));
      @(negedge clk);
      chk("f1_valid_d", 64'(lane_valid), 64'(3'b110));
      @(negedge clk);
      chk("f1_valid_e", 64'(lane_valid), 64'(3'b100));
      chk("f1_done", 64'(done), 64'(1));
      chk("f1_lane2_c2", 64'(lane_data[2*WW +: WW]), 64'(c[2][2*WW +: WW]));
      chk("f1_busy_end", 64'(busy), 64'(0));
      @(negedge clk);
      chk("f1_done_gone", 64'(done), 64'(0));
      chk("f1_issued", 64'(issued_cnt), 64'(3));

      // Fill with en low: four accepts, then in_ready drops
      for (int i = 0; i < 6; i++) begin
         c[i] = {$urandom, $urandom, $urandom};
      end
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = c[i]; in_last = (i == 3);
         @(negedge clk);
         if (i == 2) chk("fill_ready_3", 64'(in_ready), 64'(1));
         if (i == 3) chk("fill_ready_full", 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("fill_hold_issued", 64'(issued_cnt), 64'(3));
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("drain_order_%0d", i), 64'(lane_data[WW-1:0]), 64'(c[i][WW-1:0]));
         if (i == 0) chk("drain_ready_back", 64'(in_ready), 64'(1));
      end
      repeat (4) @(negedge clk);
      chk("drain_issued", 64'(issued_cnt), 64'(7));
      chk("drain_busy", 64'(busy), 64'(0));

      // Reset while draining with two columns queued
      in_valid = 1'b1; in_data = c[0]; in_last = 1'b1;
      @(negedge clk);                                   // accept A (last)
      in_data = c[1]; in_last = 1'b0;
      @(negedge clk);                                   // accept B, pop A
      in_data = c[2];
      @(negedge clk);                                   // accept C, still draining
      in_valid = 1'b0;
      chk("abort_busy", 64'(busy), 64'(1));
      #1 reset_l = 1'b0;
      #1;
      chk("abort_lane_valid", 64'(lane_valid), 64'(0));
      chk("abort_lane_data", 64'(lane_data[63:0]), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_busy_clr", 64'(busy), 64'(0));
      chk("abort_issued", 64'(issued_cnt), 64'(0));
      @(negedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);
      chk("abort_ready", 64'(in_ready), 64'(1));
      chk("abort_busy_rel", 64'(busy), 64'(0));
      repeat (4) @(negedge clk);

      // Randomized traffic, with an asynchronous reset in the middle
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(0, 4) != 0);
         in_valid = $urandom_range(0, 1) == 1;
         in_data  = {$urandom, $urandom, $urandom};
         in_last  = ($urandom_range(0, 3) == 0);
         if (i == 1500) begin
            #2 reset_l = 1'b0;
            @(negedge clk);
            reset_l = 1'b1;
         end
         @(negedge clk);
      end

      // Counter wrap: 65537 pops from a clean start
      in_valid = 1'b0; en = 1'b0;
      @(negedge clk);
      #1 reset_l = 1'b0;
      @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);
      en = 1'b1; in_valid = 1'b1; in_last = 1'b0;
      for (int i = 0; i < 65537; i++) begin
         in_data = {$urandom, $urandom, $urandom};
         @(negedge clk);
         if (i == 65534) chk("wrap_fffe", 64'(issued_cnt), 64'(16'hFFFE));
      end
      chk("wrap_0000", 64'(issued_cnt), 64'(16'h0000));
      in_valid = 1'b0;
      @(negedge clk);
      chk("wrap_0001", 64'(issued_cnt), 64'(16'h0001));
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_feeder.md
EDGE_FEEDER -- requirements
Module: edge_feeder

Interface
REQ-001 Parameter YMAX, default 3: number of row lanes driven into the PE array left edge.
REQ-002 Parameter DW, default 16: width of each of the two dbus fields; one lane word is 2*DW bits, packed {field1, field0}, matching proj_pkgs::dbus_t order.
REQ-003 Parameter DEPTH, default 4: column FIFO depth; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset_l, input, 1: reset, asynchronous and active-low.
REQ-006 Port en, input, 1: global advance enable; 0 freezes FIFO pop, skew pipeline, FSM and counters.
REQ-007 Port in_valid, input, 1: in_data/in_last hold a column.
REQ-008 Port in_ready, output, 1: feeder can accept a column.
REQ-009 Port in_data, input, YMAX*2*DW: one column; lane y occupies bits [y*2*DW +: 2*DW].
REQ-010 Port in_last, input, 1: the column is the final column of a frame.
REQ-011 Port lane_data, output, YMAX*2*DW: skewed words to array row inputs, same lane packing.
REQ-012 Port lane_valid, output, YMAX: per-lane word valid.
REQ-013 Port busy, output, 1: FSM not in IDLE.
REQ-014 Port done, output, 1: one-cycle pulse at frame completion.
REQ-015 Port issued_cnt, output, 16: number of columns popped since reset.

Function
REQ-016 A column is accepted at a rising edge where in_valid=1 and in_ready=1; the column and in_last are written to the FIFO.
REQ-017 in_ready = FIFO not full, registered from occupancy only, with no combinational path from in_valid or en.
REQ-018 The FIFO has no fall-through: a column written at edge E is poppable no earlier than edge E+1.
REQ-019 Pop happens at an edge where en=1, the FIFO is non-empty and the FSM is in IDLE or RUN.
REQ-020 On pop, lane 0's lane_data and lane_valid[0] are loaded from the head column at that edge.
REQ-021 Lane y (y>=1) receives its head-column word through y extra register stages: it is visible after edge P+y, where P is the pop edge, counting only edges with en=1.
REQ-022 At an en=1 edge with no pop, lane 0 loads lane_valid[0]=0 with lane_data held at its previous value; higher lanes shift as normal.
REQ-023 With en=0, all lane registers, the FIFO read side, the FSM, the drain counter and issued_cnt hold; FIFO writes are still accepted.
REQ-024 Simultaneous push and pop on the same edge is legal and leaves occupancy unchanged.
REQ-025 issued_cnt increments by 1 per pop and wraps from 0xFFFF to 0x0000.
REQ-026 The FSM has three states: IDLE, RUN and DRAIN.
 - IDLE -> RUN on any pop whose column has last=0.
 - IDLE or RUN -> DRAIN on a pop whose column has last=1; the drain counter loads YMAX-1.
 - DRAIN: no pops; the counter decrements on each en=1 edge; at the edge where it reaches 0, the FSM returns to IDLE.
REQ-027 done=1 for exactly the one cycle in which lane_valid[YMAX-1] carries the last=1 column's word; the FSM enters IDLE on that same edge.
REQ-028 For YMAX=1, DRAIN is bypassed: the last-column pop goes directly to IDLE, and done is asserted together with lane_valid[0].
REQ-029 A single-column frame (in_last=1 on the first column) is legal and goes IDLE -> DRAIN.
REQ-030 busy=1 in RUN and DRAIN, and 0 in IDLE.

Reset
REQ-031 reset_l=0 asynchronously clears: FIFO pointers and occupancy, lane_data=0, lane_valid=0, FSM=IDLE, drain counter=0, done=0 and issued_cnt=0; in_ready=1 from the first edge after reset_l rises.
REQ-032 Reset mid-frame discards all FIFO and pipeline contents, and no done pulse is produced for the aborted frame.

Verification (YMAX=3, DW=16, DEPTH=4)
REQ-033 Push 3 columns with en=1, the last with in_last=1 -> lane 0 valid on 3 consecutive cycles starting 2 edges after the first accept; lane 2 lags lane 0 by 2 cycles; done pulses with lane 2 of column 3; issued_cnt=3; busy returns to 0.
REQ-034 Push 6 columns back-to-back with en=0 -> in_ready drops after 4 accepts; raising en drains the FIFO at 1 pop per cycle, in_ready returns, and column order is preserved.
REQ-035 Pop two frames back-to-back -> the second frame's first pop occurs no earlier than the done edge of frame 1; no lane word of frame 2 overlaps frame 1 on lane 2.
REQ-036 Toggle en=0 for 2 cycles mid-frame -> all lane outputs and busy hold; skew spacing and done timing resume shifted by exactly 2 cycles.
REQ-037 Preload issued_cnt=0xFFFE via 65534 pops, then pop 3 more -> issued_cnt reads 0x0001.
REQ-038 Assert reset_l=0 while in DRAIN with the FIFO holding 2 columns -> outputs clear immediately; no done pulse; in_ready=1 and busy=0 after release.
